irq_capture_ctrl: RTL and testbench

Interrupt capture controller directly downstream of the 8-line priority encoder. It consumes the encoder's active-low code, GS and EO outputs, and filters the code for glitches. It latches a single interrupt ID, presents it to the CPU with a req/ack handshake, and holds the encoder disabled through its EI input while the interrupt is serviced and for a programmable hold-off afterwards.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_holdoff_timer.sv | 45 ++++
 rtl/irq_capture_ctrl.sv | 169 ++++++++++++++++
 tb/tb_irq_capture_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//
// Shared definitions for the interrupt capture controller:
//   - state_t    : controller state encoding (IDLE, QUAL, REQ, SERVICE, HOLD)
//   - ID_W       : width of an interrupt ID / encoder code
//   - decode_id  : converts the encoder's active-low code into a line number
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int ID_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL    = 3'd1,
        REQ     = 3'd2,
        SERVICE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // The encoder reports line 7 as 3'b000, so the line number is the
    // bitwise complement of its code.
    function automatic logic [ID_W-1:0] decode_id(input logic [ID_W-1:0] code_n);
        return ~code_n;
    endfunction

endpackage : irq_pkg

// File: rtl/irq_holdoff_timer.sv
// ---------------------------------------------------------------------------
// irq_holdoff_timer
//
// Load/decrement down-counter used to keep the encoder disabled for a fixed
// number of cycles after end-of-interrupt.
//
// Parameters:
//   HOLDOFF  number of hold-off cycles (must be > 0 when instantiated)
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   load  in   load the counter with HOLDOFF-1
//   dec   in   decrement the counter by one
//   done  out  counter currently reads zero
// ---------------------------------------------------------------------------
module irq_holdoff_timer #(
    parameter int HOLDOFF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [W-1:0] cnt;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(HOLDOFF - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule : irq_holdoff_timer

// File: rtl/irq_capture_ctrl.sv
// ---------------------------------------------------------------------------
// irq_capture_ctrl
//
// Sits directly behind an 8-line priority encoder. Qualifies the encoder's
// active-low code over two consecutive samples, latches a single interrupt
// ID, hands it to the CPU with a req/ack handshake and keeps the encoder
// disabled (via its EI input) while the interrupt is serviced and for
// HOLDOFF cycles after end-of-interrupt.
//
// Parameters:
//   HOLDOFF   cycles the encoder stays disabled after EOI (0 = none)
//   CNT_W     width of the saturating serviced-interrupt counter
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   enc_code_n  in   encoder code, active-low (3'b000 = line 7)
//   enc_gs_n    in   encoder GS, low when at least one line is active
//   enc_eo_n    in   encoder EO, low when enabled with no line active
//   enc_en_n    out  encoder EI, active-low enable (high in SERVICE/HOLD)
//   irq_req     out  interrupt request to the CPU
//   irq_id      out  latched interrupt ID
//   irq_ack     in   CPU accept pulse
//   irq_eoi     in   CPU end-of-interrupt pulse
//   busy        out  high in REQ, SERVICE and HOLD
//   irq_count   out  saturating count of captured interrupts
//   err         out  sticky flag: GS and EO seen low together
// ---------------------------------------------------------------------------
module irq_capture_ctrl
    import irq_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   enc_code_n,
    input  logic              enc_gs_n,
    input  logic              enc_eo_n,
    output logic              enc_en_n,
    output logic              irq_req,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    input  logic              irq_eoi,
    output logic              busy,
    output logic [CNT_W-1:0]  irq_count,
    output logic              err
);

    state_t          state;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sample_id;
    logic            illegal;
    logic            hold_load;
    logic            hold_dec;
    logic            hold_done;

    // GS and EO can never both be low on a healthy encoder; such a sample
    // is treated as corrupt and never allowed to advance qualification.
    assign illegal   = !enc_gs_n && !enc_eo_n;
    assign sample_id = decode_id(enc_code_n);

    assign hold_load = (state == SERVICE) && irq_eoi;
    assign hold_dec  = (state == HOLD) && !hold_done;

    // The encoder is gated off for the whole service window.
    assign enc_en_n  = (state == SERVICE) || (state == HOLD);

    generate
        if (HOLDOFF > 0) begin : g_holdoff
            irq_holdoff_timer #(
                .HOLDOFF (HOLDOFF)
            ) u_holdoff_timer (
                .clk  (clk),
                .rst  (rst),
                .load (hold_load),
                .dec  (hold_dec),
                .done (hold_done)
            );
        end else begin : g_no_holdoff
            // HOLD is never entered without a hold-off period.
            assign hold_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every control and output register has a reset value so a
            // reset mid-transaction leaves nothing pending to replay.
            state     <= IDLE;
            cand      <= '0;
            irq_req   <= 1'b0;
            irq_id    <= '0;
            busy      <= 1'b0;
            irq_count <= '0;
            err       <= 1'b0;
        end else begin
            if (illegal) begin
                err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!illegal && !enc_gs_n) begin
                        cand  <= sample_id;
                        state <= QUAL;
                    end
                end

                // Glitch filter: the code must match on two consecutive
                // samples; a changed code restarts qualification with the
                // new value rather than dropping back to IDLE.
                QUAL: begin
                    if (!illegal) begin
                        if (enc_gs_n) begin
                            state <= IDLE;
                        end else if (sample_id == cand) begin
                            state   <= REQ;
                            irq_req <= 1'b1;
                            irq_id  <= cand;
                            busy    <= 1'b1;
                            if (irq_count != '1) begin
                                irq_count <= irq_count + 1'b1;
                            end
                        end else begin
                            cand <= sample_id;
                        end
                    end
                end

                // EOI is deliberately not looked at here, even when it
                // coincides with the ack.
                REQ: begin
                    if (irq_ack) begin
                        state   <= SERVICE;
                        irq_req <= 1'b0;
                    end
                end

                SERVICE: begin
                    if (irq_eoi) begin
                        if (HOLDOFF == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end

                // The timer was loaded with HOLDOFF-1 on EOI; leaving in the
                // cycle after it reads zero gives exactly HOLDOFF cycles here.
                HOLD: begin
                    if (hold_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : irq_capture_ctrl

// File: tb/tb_irq_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_capture_ctrl
//
// Directed, table-driven bench for irq_capture_ctrl. A main instance
// (HOLDOFF=4, CNT_W=8) and a narrow-counter instance (HOLDOFF=4, CNT_W=2)
// share the same stimulus. Each table row gives the inputs for one clock edge
// and the outputs expected just after that edge; hand-written sequences cover
// asynchronous reset and counter saturation.
// ---------------------------------------------------------------------------
module tb_irq_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] enc_code_n;
    logic       enc_gs_n;
    logic       enc_eo_n;
    logic       irq_ack;
    logic       irq_eoi;

    logic       enc_en_n;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] irq_count;
    logic       err;

    logic       s_enc_en_n;
    logic       s_irq_req;
    logic [2:0] s_irq_id;
    logic       s_busy;
    logic [1:0] s_irq_count;
    logic       s_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    irq_capture_ctrl #(.HOLDOFF(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enc_code_n (enc_code_n),
        .enc_gs_n   (enc_gs_n),
        .enc_eo_n   (enc_eo_n),
        .enc_en_n   (enc_en_n),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .busy       (busy),
        .irq_count  (irq_count),
        .err        (err)
    );

    irq_capture_ctrl #(.HOLDOFF(4), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .enc_code_n (enc_code_n),
        .enc_gs_n   (enc_gs_n),
        .enc_eo_n   (enc_eo_n),
        .enc_en_n   (s_enc_en_n),
        .irq_req    (s_irq_req),
        .irq_id     (s_irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .busy       (s_busy),
        .irq_count  (s_irq_count),
        .err        (s_err)
    );

    typedef struct {
        logic       gs_n;
        logic       eo_n;
        logic [2:0] code_n;
        logic       ack;
        logic       eoi;
        logic       req;
        logic [2:0] id;
        logic       en_n;
        logic       busy;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic gs_n, input logic eo_n, input logic [2:0] code_n,
                                input logic ack, input logic eoi,
                                input logic req, input logic [2:0] id, input logic en_n,
                                input logic bsy, input logic [7:0] cnt, input logic er);
        vec_t v;
        v.gs_n = gs_n; v.eo_n = eo_n; v.code_n = code_n; v.ack = ack; v.eoi = eoi;
        v.req = req; v.id = id; v.en_n = en_n; v.busy = bsy; v.cnt = cnt; v.err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // {req, id, en_n, busy, count, err} of the main instance
    function automatic logic [31:0] main_outs();
        return {17'd0, irq_req, irq_id, enc_en_n, busy, irq_count, err};
    endfunction

    function automatic logic [31:0] pack_exp(input logic req, input logic [2:0] id,
                                             input logic en_n, input logic bsy,
                                             input logic [7:0] cnt, input logic er);
        return {17'd0, req, id, en_n, bsy, cnt, er};
    endfunction

    task automatic drive(input logic gs_n, input logic eo_n, input logic [2:0] code_n,
                         input logic ack, input logic eoi);
        enc_gs_n = gs_n; enc_eo_n = eo_n; enc_code_n = code_n;
        irq_ack = ack; irq_eoi = eoi;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", main_outs(), pack_exp(0, 3'd0, 0, 0, 8'd0, 0));

        // cols: gs_n eo_n code_n ack eoi | req id en_n busy cnt err
        // Capture of code 010 -> ID 5, handshake, 4-cycle hold-off with the
        // line still asserted, then automatic re-capture two cycles later.
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd0,0,0,8'd0,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd0,0,0,8'd0,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 1,3'd5,0,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 1,3'd5,0,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,1,0, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,1, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,1,1,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,0,0,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 0,3'd5,0,0,8'd1,0));
        vecs.push_back(mk(0,1,3'b010,0,0, 1,3'd5,0,1,8'd2,0));
        vecs.push_back(mk(0,1,3'b010,1,0, 0,3'd5,1,1,8'd2,0));
        vecs.push_back(mk(1,0,3'b000,0,1, 0,3'd5,1,1,8'd2,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd5,1,1,8'd2,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd5,1,1,8'd2,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd5,1,1,8'd2,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd5,0,0,8'd2,0));
        // Glitch filter: 110 for one sample, then 001 held -> ID 6.
        vecs.push_back(mk(0,1,3'b110,0,0, 0,3'd5,0,0,8'd2,0));
        vecs.push_back(mk(0,1,3'b001,0,0, 0,3'd5,0,0,8'd2,0));
        vecs.push_back(mk(0,1,3'b001,0,0, 1,3'd6,0,1,8'd3,0));
        // EOI alone in REQ is ignored; ACK+EOI together only acks.
        vecs.push_back(mk(0,1,3'b001,0,1, 1,3'd6,0,1,8'd3,0));
        vecs.push_back(mk(0,1,3'b001,1,1, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,1, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,1,1,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,0,0,8'd3,0));
        // ACK and EOI in IDLE are ignored.
        vecs.push_back(mk(1,0,3'b000,1,0, 0,3'd6,0,0,8'd3,0));
        vecs.push_back(mk(1,0,3'b000,0,1, 0,3'd6,0,0,8'd3,0));
        // Illegal samples in IDLE: err sets, nothing captured.
        vecs.push_back(mk(0,0,3'b000,0,0, 0,3'd6,0,0,8'd3,1));
        vecs.push_back(mk(0,0,3'b000,0,0, 0,3'd6,0,0,8'd3,1));
        vecs.push_back(mk(1,0,3'b000,0,0, 0,3'd6,0,0,8'd3,1));
        // Illegal sample in QUAL holds qualification in place.
        vecs.push_back(mk(0,1,3'b011,0,0, 0,3'd6,0,0,8'd3,1));
        vecs.push_back(mk(0,0,3'b011,0,0, 0,3'd6,0,0,8'd3,1));
        vecs.push_back(mk(0,1,3'b011,0,0, 1,3'd4,0,1,8'd4,1));
        vecs.push_back(mk(0,1,3'b011,1,0, 0,3'd4,1,1,8'd4,1));

        foreach (vecs[i]) begin
            drive(vecs[i].gs_n, vecs[i].eo_n, vecs[i].code_n, vecs[i].ack, vecs[i].eoi);
            step();
            check($sformatf("vec%0d", i), main_outs(),
                  pack_exp(vecs[i].req, vecs[i].id, vecs[i].en_n, vecs[i].busy,
                           vecs[i].cnt, vecs[i].err));
        end
        check("sat_cnt_pre_reset", 32'(s_irq_count), 32'd3);

        // Asynchronous reset while in SERVICE: outputs clear without a clock.
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", main_outs(), pack_exp(0, 3'd0, 0, 0, 8'd0, 0));
        check("rst_async_sat", 32'(s_irq_count), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("rst_no_replay", main_outs(), pack_exp(0, 3'd0, 0, 0, 8'd0, 0));

        // Saturation: five full capture/ack/eoi rounds.
        for (int n = 1; n <= 5; n++) begin
            logic [2:0] code;
            code = 3'(n);
            drive(1'b0, 1'b1, code, 1'b0, 1'b0);
            step();
            step();
            check($sformatf("sat_req%0d", n), main_outs(),
                  pack_exp(1, ~code, 0, 1, 8'(n), 0));
            check($sformatf("sat_cnt%0d", n), 32'(s_irq_count), (n > 3) ? 32'd3 : 32'(n));
            drive(1'b0, 1'b1, code, 1'b1, 1'b0);
            step();
            drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
            step();
            drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
            repeat (4) step();
            check($sformatf("sat_idle%0d", n), main_outs(),
                  pack_exp(0, ~code, 0, 0, 8'(n), 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_irq_capture_ctrl
